serial_tx_arbiter: RTL and testbench
====================================

// Module: serial_tx_arbiter
// PURPOSE
//  Shares the single AVR serial TX byte channel among NUM_REQ on-chip requesters.
//  Examples of requesters: CPU serial port, debug monitor, status streamer.
//  Sits between the requesters and the avr_interface TX handshake (tx_data/new_tx_data/tx_busy/tx_block).
//  Picks one requester per byte, round-robin; sequences strobe and busy handshake; flags a lost handshake.
// PARAMETERS
//  NUM_REQ      4     number of requesters, 2..8
//  ID_W         2     grant index width, must equal clog2(NUM_REQ)
//  ACK_TIMEOUT  16    cycles to wait for tx_busy after strobe before declaring error, >=2
// PORTS
//  clk          in   1          system clock
//  rst          in   1          synchronous, active-high reset
//  req_valid    in   NUM_REQ    requester i has a byte pending
//  req_data     in   8*NUM_REQ  byte of requester i at [8i+7:8i]
//  req_lock     in   NUM_REQ    requester i wants to hold the channel (SERIAL_ARB_LOCK_EN only)
//  req_ready    out  NUM_REQ    one-hot, 1-cycle pulse: byte of requester i accepted
//  tx_data      out  8          byte to avr_interface
//  new_tx_data  out  1          1-cycle send strobe to avr_interface
//  tx_busy      in   1          avr_interface transmitting
//  tx_block     in   1          AVR RX buffer full, do not start a byte
//  grant_id     out  ID_W       index of the current or last granted requester
//  active       out  1          1 in any state other than IDLE
//  timeout_err  out  1          sticky: tx_busy never rose within ACK_TIMEOUT
// BEHAVIOUR
//  Reset values:
//   - all outputs 0
//   - state IDLE
//   - last_grant = NUM_REQ-1, so requester 0 wins first
//   - timeout counter 0
//  Reset mid-byte aborts immediately. No strobe is issued on the reset cycle or the cycle after.
//  FSM states: IDLE, SEND, WAIT_START, WAIT_DONE.
//  IDLE:
//   - Arbitrate only when |req_valid && !tx_busy && !tx_block.
//   - Winner: first valid index scanning last_grant+1 .. last_grant+NUM_REQ, modulo NUM_REQ.
//   - Same cycle: req_ready[winner]=1; tx_data<=req_data[winner]; grant_id<=winner; last_grant<=winner.
//   - Next state: SEND.
//  SEND:
//   - new_tx_data=1 for exactly this cycle; tx_data stable.
//   - Clear timeout counter; next state WAIT_START.
//  WAIT_START:
//   - tx_busy=1 -> WAIT_DONE.
//   - Otherwise increment counter. At ACK_TIMEOUT set timeout_err and return to IDLE; the byte is dropped, not retried.
//  WAIT_DONE:
//   - Stay while tx_busy=1; tx_busy=0 -> IDLE.
//   - tx_block changes here are ignored.
//  Latency:
//   - req_ready pulse at cycle N; new_tx_data at N+1.
//   - Earliest next req_ready is the cycle after tx_busy falls.
//  tx_data holds its value until the next accept. req_data is sampled only in the accept cycle.
//  A requester that drops req_valid before being granted loses nothing. No ready is issued to it.
//  tx_block and tx_busy are checked in IDLE only. tx_block rising after accept does not cancel the strobe.
//  timeout_err is cleared only by rst.
//  Fairness: with all requesters valid, grants cycle 0,1,..,NUM_REQ-1,0.
// CONFIGURATION
//  SERIAL_ARB_LOCK_EN defined:
//   - If req_lock[g]=1 at the accept cycle, IDLE arbitration is restricted to g while req_lock[g] stays 1.
//   - Other requesters wait even if g has no valid byte.
//   - Lock releases in the first IDLE cycle with req_lock[g]=0. Normal round-robin then resumes from g+1.
//   - Use case: multi-byte packets stay contiguous.
//  SERIAL_ARB_LOCK_EN undefined:
//   - req_lock is ignored (left unconnected internally). Pure per-byte round-robin.
// TESTING
//  1. Only req0 valid, data 8'h41; tx_busy high 2 cycles after strobe for 10 cycles:
//     req_ready=4'b0001 at N, new_tx_data at N+1, tx_data=8'h41, grant_id=0.
//  2. All 4 valid continuously, bytes 8'hA0..8'hA3:
//     tx_data sequence A0,A1,A2,A3,A0; exactly one new_tx_data per tx_busy pulse.
//  3. tx_block=1 with req2 valid for 50 cycles:
//     no req_ready, no strobe. After tx_block falls, req_ready=4'b0100 within 1 cycle.
//  4. tx_busy never asserts after a strobe:
//     timeout_err=1 at strobe+ACK_TIMEOUT (16); FSM back in IDLE; next byte still served.
//  5. rst asserted in WAIT_DONE:
//     next cycle all outputs 0, active=0. First grant after reset goes to req0.
//  6. (LOCK_EN) req1 valid with lock held for 3 bytes, req0/req3 also valid:
//     grants 1,1,1, then 2? no, 3 (skip invalid 2), then 0.

Source files
------------

// File: rtl/serial_tx_arbiter_if.sv
// Handshake bundle shared by the requesters, serial_tx_arbiter and the avr_interface TX port.
// The slave modport is the arbiter's view; the master modport is the requester/AVR side.
interface serial_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_lock;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 new_tx_data;
   logic                 tx_busy;
   logic                 tx_block;
   logic [ID_W-1:0]      grant_id;
   logic                 active;
   logic                 timeout_err;

   modport slave (
      input  req_valid, req_data, req_lock, tx_busy, tx_block,
      output req_ready, tx_data, new_tx_data, grant_id, active, timeout_err
   );

   modport master (
      output req_valid, req_data, req_lock, tx_busy, tx_block,
      input  req_ready, tx_data, new_tx_data, grant_id, active, timeout_err
   );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing the AVR serial TX byte channel among NUM_REQ requesters.
// Define SERIAL_ARB_LOCK_EN to let a granted requester hold the channel via req_lock.
module serial_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = 2,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   serial_tx_arbiter_if.slave       bus
);
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_SEND       = 2'd1,
      S_WAIT_START = 2'd2,
      S_WAIT_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ID_W-1:0]    r_last_grant;
   logic [ID_W-1:0]    r_grant_id;
   logic [ID_W-1:0]    w_winner;
   logic               w_found;
   logic               w_accept;
   logic               w_timeout;
   logic [NUM_REQ-1:0] w_eligible;
   logic [NUM_REQ-1:0] w_req_ready;
   logic [7:0]         r_tx_data;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_new_tx_data;
   logic               r_active;
   logic               r_timeout_err;

   // First eligible index after 'last', wrapping; MSB of the result flags a hit.
   function automatic logic [ID_W:0] pick(input logic [NUM_REQ-1:0] elig,
                                          input logic [ID_W-1:0]    last);
      logic [ID_W:0] res;
      int            idx;
      res = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = (int'(last) + i) % NUM_REQ;
         res = elig[idx] ? {1'b1, ID_W'(idx)} : res;
      end
      return res;
   endfunction

`ifdef SERIAL_ARB_LOCK_EN
   logic            r_locked;
   logic [ID_W-1:0] r_lock_id;
   logic            w_lock_hold;

   // Restrict arbitration to the lock owner while it keeps req_lock high.
   always_comb begin
      w_lock_hold = r_locked && bus.req_lock[r_lock_id];
      if (w_lock_hold) begin
         w_eligible = bus.req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_lock_id);
      end else begin
         w_eligible = bus.req_valid;
      end
   end

   // Lock ownership: taken at accept, dropped in the first IDLE cycle without req_lock.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_locked  <= 1'b0;
         r_lock_id <= '0;
      end else if (w_accept) begin
         r_locked  <= bus.req_lock[w_winner];
         r_lock_id <= w_winner;
      end else if ((r_state == S_IDLE) && !w_lock_hold) begin
         r_locked  <= 1'b0;
      end
   end
`else
   assign w_eligible = bus.req_valid;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic, arbitration and the accept handshake.
   always_comb begin
      w_state_nxt         = r_state;
      w_accept            = 1'b0;
      w_timeout           = 1'b0;
      w_req_ready         = '0;
      {w_found, w_winner} = pick(w_eligible, r_last_grant);
      case (r_state)
         S_IDLE: begin
            if (w_found && !bus.tx_busy && !bus.tx_block && !rst) begin
               w_accept    = 1'b1;
               w_req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
               w_state_nxt = S_SEND;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_SEND: w_state_nxt = S_WAIT_START;
         S_WAIT_START: begin
            // r_cnt counts WAIT_START cycles; the strobe cycle makes up the remaining one.
            if (bus.tx_busy) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 2)) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_WAIT_START;
            end
         end
         S_WAIT_DONE: begin
            if (bus.tx_busy) begin
               w_state_nxt = S_WAIT_DONE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath registers: captured byte, grant history, strobe, ack counter, sticky error.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_data     <= 8'h00;
         r_grant_id    <= '0;
         r_last_grant  <= ID_W'(NUM_REQ - 1);
         r_new_tx_data <= 1'b0;
         r_active      <= 1'b0;
         r_cnt         <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_new_tx_data <= w_accept;
         r_active      <= (w_state_nxt != S_IDLE);
         if (w_accept) begin
            r_tx_data    <= bus.req_data[{w_winner, 3'b000} +: 8];
            r_grant_id   <= w_winner;
            r_last_grant <= w_winner;
         end
         if (r_state == S_SEND) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT_START) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   // req_ready is the same-cycle acknowledge of the byte being sampled.
   assign bus.req_ready   = w_req_ready;
   assign bus.tx_data     = r_tx_data;
   assign bus.new_tx_data = r_new_tx_data;
   assign bus.grant_id    = r_grant_id;
   assign bus.active      = r_active;
   assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: directed requester loads push expected grants,
// a monitor pops and checks at every new_tx_data strobe.
module tb_serial_tx_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int ID_W        = 2;
   localparam int ACK_TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   serial_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

   serial_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
   } exp_t;

   exp_t       sb_q [$];
   logic [7:0] rq [NUM_REQ][$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc = 0;
   int         strobes = 0;
   int         strobe_cyc = 0;
   int         readies = 0;
   int         busy_pulses = 0;
   bit         resp_en = 1'b1;
   logic [3:0] prev_ready = 4'b0000;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit rq_empty();
      bit e = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic expect_byte(input logic [1:0] id, input logic [7:0] data);
      exp_t e;
      e.id = id;
      e.data = data;
      sb_q.push_back(e);
      rq[id].push_back(data);
   endtask

   // Requester model: each requester presents the head of its byte queue; pops on accept.
   initial begin
      logic [3:0] acc;
      logic [31:0] d;
      logic [3:0] v;
      logic [3:0] lk;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_lock  = '0;
      forever begin
         @(negedge clk);
         acc = bus.req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i] && rq[i].size() != 0) void'(rq[i].pop_front());
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            v[i]         = (rq[i].size() != 0);
            d[i*8 +: 8]  = v[i] ? rq[i][0] : 8'h00;
            lk[i]        = 1'b0;
         end
`ifdef SERIAL_ARB_LOCK_EN
         lk[1] = v[1];
`endif
         bus.req_valid = v;
         bus.req_data  = d;
         bus.req_lock  = lk;
      end
   end

   // AVR TX model: busy rises two cycles after a strobe and lasts ten cycles.
   initial begin
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.new_tx_data && resp_en) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            bus.tx_busy = 1'b1;
            busy_pulses++;
            repeat (10) @(posedge clk);
            #1 bus.tx_busy = 1'b0;
         end
      end
   end

   // Monitor: every strobe must match the next scoreboard entry.
   initial begin
      exp_t e;
      logic [3:0] oh;
      forever begin
         @(negedge clk);
         if (bus.new_tx_data) begin
            strobes++;
            strobe_cyc = cyc;
            if (sb_q.size() == 0) begin
               check("unexpected_strobe", 32'(bus.tx_data), 32'hFFFF_FFFF);
            end else begin
               e  = sb_q.pop_front();
               oh = 4'b0001 << e.id;
               check("tx_data",   32'(bus.tx_data), 32'(e.data));
               check("grant_id",  32'(bus.grant_id), 32'(e.id));
               check("ready_prev", 32'(prev_ready), 32'(oh));
            end
         end
         if (bus.req_ready != 4'b0000) readies++;
         prev_ready = bus.req_ready;
      end
   end

   task automatic do_reset(input string name);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({name, "_rst_ready"},  32'(bus.req_ready),   32'h0);
      check({name, "_rst_txdata"}, 32'(bus.tx_data),     32'h0);
      check({name, "_rst_strobe"}, 32'(bus.new_tx_data), 32'h0);
      check({name, "_rst_grant"},  32'(bus.grant_id),    32'h0);
      check({name, "_rst_active"}, 32'(bus.active),      32'h0);
      check({name, "_rst_tmo"},    32'(bus.timeout_err), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit done = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         @(negedge clk);
         done = (sb_q.size() == 0) && rq_empty() && !bus.active && !bus.tx_busy;
      end
      check({name, "_drained"}, 32'(done), 32'h1);
   endtask

   task automatic wait_strobe(input string name, input int budget);
      int s0 = strobes;
      bit seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         seen = (strobes != s0);
      end
      check({name, "_strobe_seen"}, 32'(seen), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int b0;
      int r0;
      int t_seen;
      bit got;
      bus.tx_block = 1'b0;
      do_reset("t0");

      // Single requester, single byte.
      expect_byte(2'd0, 8'h41);
      wait_idle("t1", 100);

      // All four valid: grants rotate 0,1,2,3,0.
      do_reset("t2");
      s0 = strobes;
      b0 = busy_pulses;
      expect_byte(2'd0, 8'hA0);
      expect_byte(2'd1, 8'hA1);
      expect_byte(2'd2, 8'hA2);
      expect_byte(2'd3, 8'hA3);
      expect_byte(2'd0, 8'hA0);
      wait_idle("t2", 300);
      check("t2_strobes", 32'(strobes - s0), 32'd5);
      check("t2_busy_pulses", 32'(busy_pulses - b0), 32'd5);

      // tx_block holds off arbitration; release grants within the same cycle.
      do_reset("t3");
      @(posedge clk); #1 bus.tx_block = 1'b1;
      s0 = strobes;
      r0 = readies;
      expect_byte(2'd2, 8'h52);
      repeat (50) @(posedge clk);
      check("t3_no_ready", 32'(readies - r0), 32'd0);
      check("t3_no_strobe", 32'(strobes - s0), 32'd0);
      #1 bus.tx_block = 1'b0;
      @(negedge clk);
      check("t3_ready_after_block", 32'(bus.req_ready), 32'h4);
      wait_idle("t3", 100);

      // No tx_busy response: sticky error at strobe+ACK_TIMEOUT, then service continues.
      do_reset("t4");
      resp_en = 1'b0;
      expect_byte(2'd1, 8'h11);
      wait_strobe("t4", 50);
      got = 1'b0;
      t_seen = 0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (bus.timeout_err) begin
            got = 1'b1;
            t_seen = cyc;
         end
      end
      check("t4_tmo_seen", 32'(got), 32'h1);
      check("t4_tmo_latency", 32'(t_seen - strobe_cyc), 32'(ACK_TIMEOUT));
      check("t4_idle_after_tmo", 32'(bus.active), 32'h0);
      resp_en = 1'b1;
      expect_byte(2'd3, 8'h33);
      wait_idle("t4", 100);
      check("t4_tmo_sticky", 32'(bus.timeout_err), 32'h1);

      // Reset in WAIT_DONE, then the first grant goes to req0.
      do_reset("t5a");
      expect_byte(2'd2, 8'h22);
      wait_strobe("t5", 50);
      repeat (3) @(negedge clk);
      check("t5_active_wait_done", 32'(bus.active), 32'h1);
      do_reset("t5b");
      expect_byte(2'd0, 8'h30);
      expect_byte(2'd3, 8'h33);
      wait_idle("t5", 200);

`ifdef SERIAL_ARB_LOCK_EN
      // req1 holds the lock for three bytes; then 3 (2 idle), then 0.
      do_reset("t6");
      expect_byte(2'd1, 8'hB1);
      expect_byte(2'd1, 8'hB2);
      expect_byte(2'd1, 8'hB3);
      wait_strobe("t6", 50);
      expect_byte(2'd3, 8'h53);
      expect_byte(2'd0, 8'h50);
      wait_idle("t6", 300);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
